// File: rtl/golden_nonce_checker.sv
// Golden-nonce checker: delays issued nonces to line up with their hashes, queues matches in a FIFO.
// Optional statistics counters are enabled by defining GOLDEN_NONCE_STATS_EN.
module golden_nonce_checker #(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned ZERO_BITS  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [31:0]  in_nonce,
  input  logic [255:0] hash,
  output logic         gn_valid,
  input  logic         gn_ready,
  output logic [31:0]  gn_nonce,
  output logic         overflow,
  output logic [15:0]  match_count,
  output logic [31:0]  checked_count
);

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W   = PTR_W + 1;

  logic [LATENCY-1:0] dv_q, dv_d;
  logic [NONCE_W-1:0] dn_q [LATENCY];
  logic [NONCE_W-1:0] dn_d [LATENCY];
  logic [NONCE_W-1:0] mem_q [FIFO_DEPTH];
  logic [NONCE_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               overflow_q, overflow_d;

  logic chk_valid_c, match_c, empty_c, full_c, push_c, pop_c;
  logic unused_hash_c;

  // Delay line mirrors the hash pipeline so each nonce meets its own hash
  always_comb begin
    dv_d    = '0;
    dv_d[0] = in_valid;
    dn_d    = dn_q;
    dn_d[0] = in_nonce;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dv_d[i] = dv_q[i-1];
      dn_d[i] = dn_q[i-1];
    end
  end

  assign chk_valid_c   = dv_q[LATENCY-1];
  assign match_c       = chk_valid_c && (hash[255 -: ZERO_BITS] == '0);
  assign empty_c       = (occ_q == '0);
  assign full_c        = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop_c         = gn_ready && !empty_c;
  assign push_c        = match_c && (!full_c || pop_c);
  assign unused_hash_c = ^hash[255-ZERO_BITS:0];

  // Result FIFO; a simultaneous pop frees the slot for a push even when full
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = dn_q[LATENCY-1];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_c && !push_c) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (match_c && !push_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      dv_q       <= dv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset: valid bits and occupancy gate its use
  always_ff @(posedge clk) begin
    dn_q  <= dn_d;
    mem_q <= mem_d;
  end

  assign gn_valid = !empty_c;
  assign gn_nonce = empty_c ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

`ifdef GOLDEN_NONCE_STATS_EN
  logic [15:0] match_cnt_q, match_cnt_d;
  logic [31:0] checked_cnt_q, checked_cnt_d;

  // Dropped matches still count as found
  always_comb begin
    match_cnt_d   = match_cnt_q + 16'(match_c);
    checked_cnt_d = checked_cnt_q + 32'(chk_valid_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_cnt_q   <= '0;
      checked_cnt_q <= '0;
    end else begin
      match_cnt_q   <= match_cnt_d;
      checked_cnt_q <= checked_cnt_d;
    end
  end

  assign match_count   = match_cnt_q;
  assign checked_count = checked_cnt_q;
`else
  assign match_count   = '0;
  assign checked_count = '0;
`endif

endmodule

// File: tb/tb_golden_nonce_checker.sv
// Scoreboard bench for golden_nonce_checker: two instances (32 and 31 zero bits) share stimulus.
module tb_golden_nonce_checker;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXC  = 4096;
`ifdef GOLDEN_NONCE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         gn_ready = 1'b0;
  logic [31:0]  in_nonce = '0;
  logic [255:0] hash = '0;

  logic         gv [2];
  logic [31:0]  gn [2];
  logic         ov [2];
  logic [15:0]  mc [2];
  logic [31:0]  cc [2];

  golden_nonce_checker #(.LATENCY(LAT), .ZERO_BITS(32), .FIFO_DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nonce(in_nonce), .hash(hash),
    .gn_valid(gv[0]), .gn_ready(gn_ready), .gn_nonce(gn[0]), .overflow(ov[0]),
    .match_count(mc[0]), .checked_count(cc[0]));

  golden_nonce_checker #(.LATENCY(LAT), .ZERO_BITS(31), .FIFO_DEPTH(DEPTH)) u_dut31 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nonce(in_nonce), .hash(hash),
    .gn_valid(gv[1]), .gn_ready(gn_ready), .gn_nonce(gn[1]), .overflow(ov[1]),
    .match_count(mc[1]), .checked_count(cc[1]));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned zb [2] = '{32, 31};

  // Reference model state: expected FIFO contents, sticky flag and counters
  logic [31:0] exp_q [2][$];
  logic        m_ov [2] = '{1'b0, 1'b0};
  logic [15:0] m_mc [2] = '{16'd0, 16'd0};
  logic [31:0] m_cc [2] = '{32'd0, 32'd0};
  logic        hist_v [MAXC];
  logic [31:0] hist_n [MAXC];
  int          cyc = 0;
  int          last_rst = 0;

  function automatic bit top_zero(input logic [255:0] h, input int unsigned bits);
    return (h >> (256 - bits)) == '0;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      hist_v[i] = 1'b0;
      hist_n[i] = '0;
    end
  end

  // Model: a nonce issued at cycle t is checked against the hash of cycle t+LAT
  // unless a reset edge occurred anywhere from t onwards.
  always @(posedge clk) begin
    if (!rst_n) begin
      last_rst = cyc;
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        m_ov[k] = 1'b0;
        m_mc[k] = '0;
        m_cc[k] = '0;
      end
    end else if (cyc >= int'(LAT) && hist_v[cyc-int'(LAT)] && (cyc - int'(LAT)) > last_rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cc[k] = m_cc[k] + 32'd1;
        if (top_zero(hash, zb[k])) begin
          m_mc[k] = m_mc[k] + 16'd1;
          if (exp_q[k].size() < int'(DEPTH)) exp_q[k].push_back(hist_n[cyc-int'(LAT)]);
          else m_ov[k] = 1'b1;
        end
      end
    end
    if (cyc < MAXC) begin
      hist_v[cyc] = in_valid;
      hist_n[cyc] = in_nonce;
    end
    cyc++;
  end

  // Monitor: compares every presented output, popping expectations on handshake
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_q[k].size() > 0) begin
        chk("gn_valid", k, 32'(gv[k]), 32'd1);
        if (rst_n && gn_ready) chk("pop_nonce", k, gn[k], exp_q[k].pop_front());
        else chk("head_nonce", k, gn[k], exp_q[k][0]);
      end else begin
        chk("gn_valid", k, 32'(gv[k]), 32'd0);
        chk("empty_nonce", k, gn[k], 32'd0);
      end
      chk("overflow", k, 32'(ov[k]), 32'(m_ov[k]));
      chk("match_count", k, 32'(mc[k]), STATS ? 32'(m_mc[k]) : 32'd0);
      chk("checked_count", k, cc[k], STATS ? m_cc[k] : 32'd0);
    end
  end

  // Driver: plan[c] selects the kind of hash presented in cycle c
  // (0 = nonzero top bit, 1 = top word zero, 2 = top word one).
  int dc = 0;
  int plan [MAXC + LAT];

  task automatic tick(input logic v, input logic [31:0] n, input int fkind, input logic rdy);
    if (dc + int'(LAT) < MAXC + int'(LAT)) plan[dc + int'(LAT)] = fkind;
    in_valid = v;
    in_nonce = n;
    gn_ready = rdy;
    for (int w = 0; w < 8; w++) hash[w*32 +: 32] = $urandom;
    case (plan[dc])
      1:       hash[255:224] = 32'h0;
      2:       hash[255:224] = 32'h1;
      default: hash[255:224] = $urandom | 32'h8000_0000;
    endcase
    @(posedge clk);
    #1;
    dc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom, 0, rdy);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MAXC + int'(LAT); i++) plan[i] = 0;
    do_reset(3);
    idle(4, 1'b1);

    // Single match latency, then near-miss hash (match only with 31 zero bits)
    tick(1'b1, 32'h0000ABCD, 1, 1'b1);
    idle(12, 1'b1);
    tick(1'b1, 32'h00001234, 2, 1'b1);
    idle(12, 1'b1);

    // Five matches with consumer stalled, then drain
    for (int i = 1; i <= 5; i++) tick(1'b1, 32'(i), 1, 1'b0);
    idle(12, 1'b0);
    idle(8, 1'b1);

    // Full FIFO with a match coinciding with a pop
    do_reset(1);
    for (int i = 11; i <= 14; i++) tick(1'b1, 32'(i), 1, 1'b0);
    tick(1'b1, 32'd15, 1, 1'b0);
    idle(int'(LAT) - 1, 1'b0);
    tick(1'b0, 32'd0, 0, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Reset while three matching nonces are in flight
    for (int i = 21; i <= 23; i++) tick(1'b1, 32'(i), 1, 1'b1);
    do_reset(1);
    idle(14, 1'b1);

    // 100 checked hashes with 3 matches
    do_reset(1);
    for (int i = 0; i < 100; i++)
      tick(1'b1, $urandom, (i == 10 || i == 50 || i == 90) ? 1 : 0, 1'b1);
    idle(12, 1'b1);

    // Randomized traffic with stall phases and occasional resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      int kind;
      logic rdy;
      r    = int'($urandom % 8);
      kind = (r >= 4 && r <= 5) ? 1 : (r == 6) ? 2 : 0;
      rdy  = ((i / 100) % 2 == 0) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      rst_n = ($urandom % 300 != 0);
      tick(1'(($urandom % 3) != 0), $urandom, kind, rdy);
    end
    rst_n = 1'b1;
    idle(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/golden_nonce_checker.md
GOLDEN_NONCE_CHECKER -- requirements
Module: golden_nonce_checker

Interface
REQ-001 Parameter LATENCY, default 8, SHALL set the cycles from nonce issue to its hash on the hash input; legal range 1..64.
REQ-002 Parameter ZERO_BITS, default 32, SHALL set how many most-significant hash bits must be zero to match; legal range 1..32.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the result FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  a nonce entered the hash pipeline this cycle.
REQ-007 in_nonce  input  32  nonce entering the hash pipeline.
REQ-008 hash  input  256  final hash from the transform pipeline; word 7 = bits 255:224.
REQ-009 gn_valid  output  1  FIFO non-empty; gn_nonce holds a golden nonce.
REQ-010 gn_ready  input  1  consumer accepts gn_nonce this cycle.
REQ-011 gn_nonce  output  32  FIFO head entry.
REQ-012 overflow  output  1  sticky; a golden nonce was dropped.
REQ-013 match_count  output  16  golden nonces found (see Configuration).
REQ-014 checked_count  output  32  hashes checked (see Configuration).

Function
REQ-015 An internal LATENCY-stage shift register SHALL delay in_valid and in_nonce, advancing every cycle.
REQ-016 In a cycle where the delayed valid is 1, hash[255:256-ZERO_BITS] SHALL be compared to zero; hash is ignored otherwise.
REQ-017 On a match the delayed nonce SHALL be pushed into the FIFO at that clock edge.
REQ-018 A nonce issued in cycle t and matching SHALL make gn_valid 1 in cycle t+LATENCY+1 when the FIFO was empty.
REQ-019 Pop SHALL occur on any edge with gn_valid=1 and gn_ready=1; gn_nonce SHALL present the next entry the following cycle.
REQ-020 FIFO order SHALL be strict first-in first-out.
REQ-021 Push and pop in the same cycle SHALL both take effect, including when full; occupancy is unchanged.
REQ-022 Push when full without pop SHALL drop the new nonce, leave FIFO contents unchanged, and set overflow to 1.
REQ-023 overflow SHALL stay 1 until reset.
REQ-024 gn_ready while empty SHALL have no effect; gn_nonce SHALL read 0 whenever the FIFO is empty.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked so that full and empty are distinguishable.
REQ-026 Counters SHALL wrap modulo 2^width without saturating.

Reset
REQ-027 With rst_n=0 at an edge: all delay-line valid bits, FIFO pointers and occupancy, overflow, and counters SHALL clear to 0.
REQ-028 Outputs after reset: gn_valid=0, gn_nonce=0, overflow=0, match_count=0, checked_count=0.
REQ-029 Nonces in flight when reset is asserted mid-operation SHALL be discarded; their hashes SHALL never be pushed.
REQ-030 Delay-line nonce data need not be reset.

Configuration
REQ-031 Macro GOLDEN_NONCE_STATS_EN defined: match_count SHALL increment on every match, including dropped ones; checked_count SHALL increment on every delayed-valid cycle.
REQ-032 GOLDEN_NONCE_STATS_EN undefined: no counter registers SHALL exist, and match_count and checked_count SHALL be constant 0.

Verification
REQ-033 LATENCY=8: in_nonce=0x0000ABCD with in_valid at cycle 10, hash[255:224]=0 at cycle 18 -> gn_valid=1 and gn_nonce=0x0000ABCD at cycle 19.
REQ-034 Delayed valid with hash[255:224]=0x00000001 (ZERO_BITS=32) -> no push; with ZERO_BITS=31 -> push.
REQ-035 gn_ready=0; five matches 1,2,3,4,5 -> FIFO holds 1..4, overflow=1; then gn_ready=1 -> pops 1,2,3,4 in order, then gn_valid=0.
REQ-036 FIFO full, and a match coincides with a pop -> 1 popped, new nonce stored, occupancy stays 4, overflow stays 0.
REQ-037 rst_n=0 for one cycle while three nonces are in flight -> no gn_valid from them, all outputs 0.
REQ-038 STATS_EN defined; 100 checked hashes with 3 matches -> checked_count=100, match_count=3; macro undefined -> both 0.
